// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder serving a bank of NUM_REGS byte-strobed 32-bit registers.
// Latency: B valid the cycle after the later of the AW/W handshakes; R valid the cycle after AR.
// Backpressure: one write and one read outstanding; READYs drop until the B/R beat is taken.
module axi4_lite_slave_regs #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_REGS   = 16,
   parameter int ADDR_LSB   = 0
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
   input  logic                    S_AWVALID,
   output logic                    S_AWREADY,
   input  logic [DATA_WIDTH-1:0]   S_WDATA,
   input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
   input  logic                    S_WVALID,
   output logic                    S_WREADY,
   output logic [1:0]              S_BRESP,
   output logic                    S_BVALID,
   input  logic                    S_BREADY,
   input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
   input  logic                    S_ARVALID,
   output logic                    S_ARREADY,
   output logic [DATA_WIDTH-1:0]   S_RDATA,
   output logic [1:0]              S_RRESP,
   output logic                    S_RVALID,
   input  logic                    S_RREADY
);
   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int STRB_W = DATA_WIDTH / 8;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_HOLD = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   // ---------------- write channel ----------------
   logic [1:0]            w_state;
   logic                  aw_held;
   logic                  w_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]     w_strb_q;
   logic [1:0]            bresp_q;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  commit;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]     wr_strb;
   logic                  wr_oor;
   logic [IDX_W-1:0]      wr_idx;

   // Each address/data channel accepts one beat per transaction and stops once held or responding.
   assign S_AWREADY = !ARESET && ((w_state == W_IDLE) || ((w_state == W_HOLD) && !aw_held));
   assign S_WREADY  = !ARESET && ((w_state == W_IDLE) || ((w_state == W_HOLD) && !w_held));

   assign aw_hs  = S_AWVALID && S_AWREADY;
   assign w_hs   = S_WVALID && S_WREADY;
   // The commit edge is whichever edge completes the second of the two beats.
   assign commit = (aw_hs || aw_held) && (w_hs || w_held);

   // A held beat takes precedence over the live bus, which is idle for that channel.
   assign wr_addr = aw_held ? aw_addr_q : S_AWADDR;
   assign wr_data = w_held  ? w_data_q  : S_WDATA;
   assign wr_strb = w_held  ? w_strb_q  : S_WSTRB;
   assign wr_oor  = (wr_addr >> ADDR_LSB) >= ADDR_WIDTH'(NUM_REGS);
   assign wr_idx  = wr_addr[ADDR_LSB +: IDX_W];

   // Write FSM: collect AW and W in either order, then hold the B response until taken.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state <= W_IDLE;
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         bresp_q <= RESP_OKAY;
      end else begin
         case (w_state)
            W_IDLE, W_HOLD: begin
               if (commit) begin
                  w_state <= W_RESP;
                  aw_held <= 1'b0;
                  w_held  <= 1'b0;
                  bresp_q <= wr_oor ? RESP_SLVERR : RESP_OKAY;
               end else if (aw_hs || w_hs) begin
                  w_state <= W_HOLD;
                  if (aw_hs) aw_held <= 1'b1;
                  if (w_hs)  w_held  <= 1'b1;
               end
            end
            W_RESP: begin
               if (S_BREADY) w_state <= W_IDLE;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Capture whichever write beat arrives first; only read back while its held flag is set.
   always_ff @(posedge ACLK) begin
      if (aw_hs) aw_addr_q <= S_AWADDR;
      if (w_hs) begin
         w_data_q <= S_WDATA;
         w_strb_q <= S_WSTRB;
      end
   end

   // Register bank: byte-lane update on the commit edge, out-of-range writes dropped.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (commit && !wr_oor) begin
         for (int k = 0; k < STRB_W; k++) begin
            if (wr_strb[k]) regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
         end
      end
   end

   assign S_BVALID = !ARESET && (w_state == W_RESP);
   assign S_BRESP  = bresp_q;

   // ---------------- read channel ----------------
   logic [0:0]            r_state;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            rresp_q;
   logic                  rd_oor;
   logic [IDX_W-1:0]      rd_idx;

   assign S_ARREADY = !ARESET && (r_state == R_IDLE);
   assign rd_oor    = (S_ARADDR >> ADDR_LSB) >= ADDR_WIDTH'(NUM_REGS);
   assign rd_idx    = S_ARADDR[ADDR_LSB +: IDX_W];

   // Read FSM: sample the bank on the AR edge (pre-commit value on a collision), hold R until taken.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state <= R_IDLE;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (S_ARVALID) begin
                  r_state <= R_DATA;
                  rdata_q <= rd_oor ? '0 : regs[rd_idx];
                  rresp_q <= rd_oor ? RESP_SLVERR : RESP_OKAY;
               end
            end
            R_DATA: begin
               if (S_RREADY) r_state <= R_IDLE;
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   assign S_RVALID = !ARESET && (r_state == R_DATA);
   assign S_RDATA  = rdata_q;
   assign S_RRESP  = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs: reset, full bank, strobes, skew, backpressure, errors, collision.
// Latency: inputs driven and outputs sampled on the falling edge, half a cycle from the DUT edge.
// Backpressure: BREADY/RREADY are held low in dedicated sequences to check output stability.
`timescale 1ns/1ps
module tb_axi4_lite_slave_regs;
   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [31:0] S_AWADDR;
   logic        S_AWVALID;
   logic        S_AWREADY;
   logic [31:0] S_WDATA;
   logic [3:0]  S_WSTRB;
   logic        S_WVALID;
   logic        S_WREADY;
   logic [1:0]  S_BRESP;
   logic        S_BVALID;
   logic        S_BREADY;
   logic [31:0] S_ARADDR;
   logic        S_ARVALID;
   logic        S_ARREADY;
   logic [31:0] S_RDATA;
   logic [1:0]  S_RRESP;
   logic        S_RVALID;
   logic        S_RREADY;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_regs [16];
   logic [31:0] bank_vals [13] = '{
      32'h0398aa44, 32'h02000000, 32'h03000000, 32'h04000000, 32'h05000000,
      32'h06000000, 32'h07000000, 32'h08000000, 32'h09000000, 32'h0a000000,
      32'h0b000000, 32'h0c000000, 32'h0d000000};
   logic [31:0] rd_d;
   logic [1:0]  rd_r;
   logic [1:0]  wr_r;

   always #5 ACLK = ~ACLK;

   axi4_lite_slave_regs #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .ADDR_LSB(0)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
      .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
      .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
      .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Full write transaction with both channels offered together; returns BRESP.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit aw_done = 1'b0;
      bit w_done  = 1'b0;
      bit aw_now;
      bit w_now;
      @(negedge ACLK);
      S_AWADDR = addr; S_AWVALID = 1'b1;
      S_WDATA = data; S_WSTRB = strb; S_WVALID = 1'b1;
      S_BREADY = 1'b0;
      for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
         aw_now = S_AWVALID && S_AWREADY;
         w_now  = S_WVALID && S_WREADY;
         @(negedge ACLK);
         if (aw_now) begin aw_done = 1'b1; S_AWVALID = 1'b0; end
         if (w_now)  begin w_done  = 1'b1; S_WVALID  = 1'b0; end
      end
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
      chk("wr_handshake", {31'd0, aw_done && w_done}, 32'd1);
      chk("wr_bvalid_after_commit", {31'd0, S_BVALID}, 32'd1);
      resp = S_BRESP;
      S_BREADY = 1'b1;
      @(negedge ACLK);
      chk("wr_bvalid_cleared", {31'd0, S_BVALID}, 32'd0);
      S_BREADY = 1'b0;
   endtask

   // Full read transaction; checks the one-cycle latency and returns data/resp.
   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      bit ar_now = 1'b0;
      @(negedge ACLK);
      S_ARADDR = addr; S_ARVALID = 1'b1; S_RREADY = 1'b0;
      for (int i = 0; i < 20 && !ar_now; i++) begin
         ar_now = S_ARREADY;
         @(negedge ACLK);
      end
      S_ARVALID = 1'b0;
      chk("rd_handshake", {31'd0, ar_now}, 32'd1);
      chk("rd_rvalid_latency", {31'd0, S_RVALID}, 32'd1);
      data = S_RDATA;
      resp = S_RRESP;
      S_RREADY = 1'b1;
      @(negedge ACLK);
      chk("rd_rvalid_cleared", {31'd0, S_RVALID}, 32'd0);
      S_RREADY = 1'b0;
   endtask

   task automatic verify_all(input string tag);
      logic [31:0] d;
      logic [1:0]  r;
      for (int i = 0; i < 16; i++) begin
         axi_read(32'(i), d, r);
         chk($sformatf("%s_reg%0d", tag, i), d, exp_regs[i]);
         chk($sformatf("%s_rresp%0d", tag, i), {30'd0, r}, 32'd0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      ARESET = 1'b1;
      S_AWADDR = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0;
      S_BREADY = 1'b0; S_ARADDR = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0;
      for (int i = 0; i < 16; i++) exp_regs[i] = 32'd0;

      // Reset state
      repeat (10) @(negedge ACLK);
      chk("rst_awready", {31'd0, S_AWREADY}, 32'd0);
      chk("rst_wready",  {31'd0, S_WREADY},  32'd0);
      chk("rst_arready", {31'd0, S_ARREADY}, 32'd0);
      chk("rst_bvalid",  {31'd0, S_BVALID},  32'd0);
      chk("rst_rvalid",  {31'd0, S_RVALID},  32'd0);
      chk("rst_bresp",   {30'd0, S_BRESP},   32'd0);
      chk("rst_rresp",   {30'd0, S_RRESP},   32'd0);
      chk("rst_rdata",   S_RDATA,            32'd0);
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("idle_awready", {31'd0, S_AWREADY}, 32'd1);
      chk("idle_wready",  {31'd0, S_WREADY},  32'd1);
      chk("idle_arready", {31'd0, S_ARREADY}, 32'd1);

      // Basic write / read-back
      axi_write(32'd0, 32'h0398aa44, 4'hF, wr_r);
      chk("t1_bresp", {30'd0, wr_r}, 32'd0);
      exp_regs[0] = 32'h0398aa44;
      axi_read(32'd0, rd_d, rd_r);
      chk("t1_rdata", rd_d, 32'h0398aa44);
      chk("t1_rresp", {30'd0, rd_r}, 32'd0);

      // Full bank, 13..15 remain zero
      for (int i = 1; i < 13; i++) begin
         axi_write(32'(i), bank_vals[i], 4'hF, wr_r);
         chk($sformatf("bank_bresp%0d", i), {30'd0, wr_r}, 32'd0);
         exp_regs[i] = bank_vals[i];
      end
      verify_all("bank");

      // Partial strobes
      axi_write(32'd0, 32'hFFFFFFFF, 4'b0101, wr_r);
      chk("strb_bresp", {30'd0, wr_r}, 32'd0);
      exp_regs[0] = 32'h03FFaaFF;
      axi_read(32'd0, rd_d, rd_r);
      chk("strb_0101_rdata", rd_d, 32'h03FFaaFF);
      axi_write(32'd0, 32'h11111111, 4'b0000, wr_r);
      chk("strb_0000_bresp", {30'd0, wr_r}, 32'd0);
      axi_read(32'd0, rd_d, rd_r);
      chk("strb_0000_rdata", rd_d, 32'h03FFaaFF);

      // AW three cycles ahead of W, then B backpressure
      @(negedge ACLK);
      S_AWADDR = 32'd1; S_AWVALID = 1'b1;
      chk("skew_awready", {31'd0, S_AWREADY}, 32'd1);
      @(negedge ACLK);
      S_AWVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("skew_awready_held", {31'd0, S_AWREADY}, 32'd0);
         chk("skew_wready_open",  {31'd0, S_WREADY},  32'd1);
         chk("skew_no_bvalid",    {31'd0, S_BVALID},  32'd0);
         if (i == 2) begin
            S_WDATA = 32'hCAFEF00D; S_WSTRB = 4'hF; S_WVALID = 1'b1;
         end
         @(negedge ACLK);
      end
      S_WVALID = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bp_bvalid",  {31'd0, S_BVALID},  32'd1);
         chk("bp_bresp",   {30'd0, S_BRESP},   32'd0);
         chk("bp_awready", {31'd0, S_AWREADY}, 32'd0);
         chk("bp_wready",  {31'd0, S_WREADY},  32'd0);
         @(negedge ACLK);
      end
      S_BREADY = 1'b1;
      @(negedge ACLK);
      S_BREADY = 1'b0;
      chk("bp_bvalid_done",   {31'd0, S_BVALID},  32'd0);
      chk("bp_awready_again", {31'd0, S_AWREADY}, 32'd1);
      chk("bp_wready_again",  {31'd0, S_WREADY},  32'd1);
      exp_regs[1] = 32'hCAFEF00D;
      axi_read(32'd1, rd_d, rd_r);
      chk("skew_rdata", rd_d, 32'hCAFEF00D);

      // W ahead of AW
      @(negedge ACLK);
      S_WDATA = 32'hA5A55A5A; S_WSTRB = 4'hF; S_WVALID = 1'b1;
      @(negedge ACLK);
      S_WVALID = 1'b0;
      chk("wfirst_wready_held", {31'd0, S_WREADY},  32'd0);
      chk("wfirst_awready",     {31'd0, S_AWREADY}, 32'd1);
      chk("wfirst_no_bvalid",   {31'd0, S_BVALID},  32'd0);
      S_AWADDR = 32'd2; S_AWVALID = 1'b1;
      @(negedge ACLK);
      S_AWVALID = 1'b0;
      chk("wfirst_bvalid", {31'd0, S_BVALID}, 32'd1);
      S_BREADY = 1'b1;
      @(negedge ACLK);
      S_BREADY = 1'b0;
      exp_regs[2] = 32'hA5A55A5A;
      axi_read(32'd2, rd_d, rd_r);
      chk("wfirst_rdata", rd_d, 32'hA5A55A5A);

      // R backpressure
      @(negedge ACLK);
      S_ARADDR = 32'd0; S_ARVALID = 1'b1; S_RREADY = 1'b0;
      @(negedge ACLK);
      S_ARVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rbp_rvalid",  {31'd0, S_RVALID},  32'd1);
         chk("rbp_rdata",   S_RDATA,            32'h03FFaaFF);
         chk("rbp_arready", {31'd0, S_ARREADY}, 32'd0);
         @(negedge ACLK);
      end
      S_RREADY = 1'b1;
      @(negedge ACLK);
      S_RREADY = 1'b0;
      chk("rbp_rvalid_done", {31'd0, S_RVALID},  32'd0);
      chk("rbp_arready",     {31'd0, S_ARREADY}, 32'd1);

      // Out of range
      axi_write(32'd20, 32'hDEADBEEF, 4'hF, wr_r);
      chk("oor_bresp", {30'd0, wr_r}, 32'd2);
      axi_read(32'd20, rd_d, rd_r);
      chk("oor_rdata", rd_d, 32'd0);
      chk("oor_rresp", {30'd0, rd_r}, 32'd2);
      verify_all("oor");

      // AR and commit to reg 5 on the same edge
      @(negedge ACLK);
      S_AWADDR = 32'd5; S_AWVALID = 1'b1;
      S_WDATA = 32'h12345678; S_WSTRB = 4'hF; S_WVALID = 1'b1;
      S_ARADDR = 32'd5; S_ARVALID = 1'b1;
      chk("col_ready_all", {29'd0, S_AWREADY, S_WREADY, S_ARREADY}, 32'd7);
      @(negedge ACLK);
      S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
      chk("col_rvalid", {31'd0, S_RVALID}, 32'd1);
      chk("col_rdata_old", S_RDATA, 32'h06000000);
      chk("col_bvalid", {31'd0, S_BVALID}, 32'd1);
      S_BREADY = 1'b1; S_RREADY = 1'b1;
      @(negedge ACLK);
      S_BREADY = 1'b0; S_RREADY = 1'b0;
      exp_regs[5] = 32'h12345678;
      axi_read(32'd5, rd_d, rd_r);
      chk("col_rdata_new", rd_d, 32'h12345678);

      // Reset while BVALID is pending
      @(negedge ACLK);
      S_AWADDR = 32'd3; S_AWVALID = 1'b1;
      S_WDATA = 32'h00000077; S_WSTRB = 4'hF; S_WVALID = 1'b1;
      @(negedge ACLK);
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
      chk("rstb_bvalid_before", {31'd0, S_BVALID}, 32'd1);
      ARESET = 1'b1;
      @(negedge ACLK);
      chk("rstb_bvalid",  {31'd0, S_BVALID},  32'd0);
      chk("rstb_awready", {31'd0, S_AWREADY}, 32'd0);
      chk("rstb_arready", {31'd0, S_ARREADY}, 32'd0);
      ARESET = 1'b0;
      for (int i = 0; i < 16; i++) exp_regs[i] = 32'd0;
      verify_all("rstb");

      // Held AW discarded by reset: a later W alone must not commit
      @(negedge ACLK);
      S_AWADDR = 32'd4; S_AWVALID = 1'b1;
      @(negedge ACLK);
      S_AWVALID = 1'b0;
      ARESET = 1'b1;
      @(negedge ACLK);
      ARESET = 1'b0;
      S_WDATA = 32'h0BADF00D; S_WSTRB = 4'hF; S_WVALID = 1'b1;
      @(negedge ACLK);
      S_WVALID = 1'b0;
      chk("rsta_no_bvalid", {31'd0, S_BVALID},  32'd0);
      chk("rsta_awready",   {31'd0, S_AWREADY}, 32'd1);
      S_AWADDR = 32'd4; S_AWVALID = 1'b1;
      @(negedge ACLK);
      S_AWVALID = 1'b0;
      chk("rsta_bvalid", {31'd0, S_BVALID}, 32'd1);
      S_BREADY = 1'b1;
      @(negedge ACLK);
      S_BREADY = 1'b0;
      exp_regs[4] = 32'h0BADF00D;
      verify_all("rsta");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
AXI4-Lite responder (slave) hosting a bank of 32-bit read/write registers. It is the far end of the team's AXI4-Lite master datapath: it accepts AW/W/AR requests, commits byte-strobed writes, returns B responses, and serves R data. It sits behind the AXI_top master so the write-then-read-back register sequences run against real storage.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported, WSTRB width is DATA_WIDTH/8.
ADDR_WIDTH, 32, AWADDR/ARADDR width.
NUM_REGS, 16, number of registers; register index width is clog2(NUM_REGS).
ADDR_LSB, 0, address bit where the register index starts; 0 = word-indexed (the master's convention, addresses 0,1,2...), 2 = byte addressing.

Ports:
ACLK  in  1  single clock, all logic on the rising edge.
ARESET  in  1  synchronous, active-high reset.
S_AWADDR  in  ADDR_WIDTH  write address.
S_AWVALID  in  1  write address valid.
S_AWREADY  out  1  write address ready.
S_WDATA  in  DATA_WIDTH  write data.
S_WSTRB  in  DATA_WIDTH/8  byte-lane strobes.
S_WVALID  in  1  write data valid.
S_WREADY  out  1  write data ready.
S_BRESP  out  2  write response (00 OKAY, 10 SLVERR).
S_BVALID  out  1  write response valid.
S_BREADY  in  1  write response ready.
S_ARADDR  in  ADDR_WIDTH  read address.
S_ARVALID  in  1  read address valid.
S_ARREADY  out  1  read address ready.
S_RDATA  out  DATA_WIDTH  read data.
S_RRESP  out  2  read response.
S_RVALID  out  1  read data valid.
S_RREADY  in  1  read data ready.

Behaviour:
- Reset: while ARESET=1, all registers are cleared to 0. BVALID, RVALID, BRESP, RRESP and RDATA are 0. All READY outputs are forced to 0.
- Reset mid-transaction: any captured AW or W and any pending B or R is discarded at the reset edge. No register write occurs unless its commit edge had already passed.
- Register index: idx = addr[ADDR_LSB +: clog2(NUM_REGS)]. An address is out of range when addr >> ADDR_LSB >= NUM_REGS.
- Write FSM states: W_IDLE, W_HOLD (exactly one of AW or W captured), W_RESP.
  - AWREADY = 1 in W_IDLE, and in W_HOLD only when AW is not yet held. WREADY follows the same rule for W.
  - AW and W may handshake in the same cycle or in any order, with any gap between them.
- Commit: happens on the edge where the second of AW/W handshakes.
  - Each register byte lane k is updated only where WSTRB[k]=1.
  - WSTRB=0 produces no change and BRESP=OKAY.
  - Out-of-range writes change no register and give BRESP=10.
  - After the commit edge the FSM enters W_RESP, with BVALID=1 from the next cycle.
- W_RESP: BVALID and BRESP are held stable until BREADY=1. During W_RESP both AWREADY and WREADY are 0. After the B handshake the FSM returns to W_IDLE, with READY=1 in the following cycle.
- Read FSM states: R_IDLE, R_DATA.
  - ARREADY = 1 only in R_IDLE.
  - On the AR handshake edge, RDATA is loaded from reg[idx] (0 if out of range), RRESP is loaded (00/10), and RVALID goes to 1 the next cycle. Read latency is 1 cycle after the handshake.
  - RDATA, RRESP and RVALID are held until RREADY=1, then the FSM returns to R_IDLE.
- Read and write channels are fully independent.
  - If an AR handshake and a write commit to the same register land on the same edge, the read returns the old value.
  - A read handshaking one edge after the commit returns the new value.
- Outputs are stable while VALID=1 and READY=0, as the protocol requires.

Test Plan:
- Reset and write/read: hold ARESET for 10 cycles, then write 0x0398aa44 with strb 0xF to addr 0 -> BRESP=00 one cycle after commit; read addr 0 -> RDATA=0x0398aa44, RRESP=00, RVALID one cycle after the AR handshake.
- Full bank: write the values 0x0398aa44...0x0d000000 to addrs 0..12, then read all back -> every value matches; addrs 13..15 read 0.
- Partial strobe: reg 0 = 0x0398aa44, write 0xFFFFFFFF with strb 0101 -> read 0x03FFaaFF; strb 0000 -> value unchanged and BRESP=00.
- Channel skew and backpressure:
  - AW handshakes 3 cycles before W -> AWREADY=0 while waiting, commit on the W edge.
  - Hold BREADY=0 for 4 cycles -> BVALID stays 1 with stable BRESP, and AWREADY/WREADY stay 0.
  - Hold RREADY=0 -> RDATA stays stable.
- Out-of-range access: write 0xDEADBEEF to addr 20 -> BRESP=10, no register changes; read addr 20 -> RDATA=0, RRESP=10.
- Collision and reset:
  - AR to reg 5 on the same edge as a commit of 0x12345678 to reg 5 -> returns the old value; the next read returns 0x12345678.
  - Assert ARESET while BVALID=1 -> BVALID=0 the next cycle, all registers read 0.
